axi_slave_mem: RTL and testbench

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

---
 rtl/axi_mem_pkg.sv | 27 ++
 rtl/axi_mem_ram.sv | 45 ++++
 rtl/axi_slave_mem.sv | 249 ++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 514 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI slave memory.
// FSM state encodings and AXI response codes.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // True when a word index lies past the end of memory.
  function automatic logic idx_oob(
    input logic [31:0] idx,
    input int unsigned depth
  );
    return idx >= depth;
  endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// Byte-enabled RAM: one write port, one registered read port.
// A same-cycle read and write of one word returns the old data.
module axi_mem_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  logic [DATA_W/8-1:0]        i_wstrb,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic                       i_re,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic [DATA_W-1:0]          o_rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  // Byte-lane writes; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read register holds its value until the next enabled read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_re) begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 INCR-burst slave backed by a synchronous RAM.
// Define AXI_MEM_ERR_EN for out-of-range and wlast SLVERR checks.
module axi_slave_mem
  import axi_mem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4,
  parameter int DEPTH  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ID_W-1:0]     awid,
  input  logic [31:0]         awaddr,
  input  logic [LEN_W-1:0]    awlen,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [31:0]         araddr,
  input  logic [LEN_W-1:0]    arlen,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF   = $clog2(NB);
  localparam int AW    = $clog2(DEPTH);
  localparam int IDX_W = 32 - OFF + 1;
  localparam int BW    = LEN_W + 1;

  wstate_e            r_wstate;
  logic [ID_W-1:0]    r_awid;
  logic [LEN_W-1:0]   r_wlen;
  logic [BW-1:0]      r_wbeat;
  logic [IDX_W-1:0]   r_widx;
  logic               r_werr;
  logic               r_bvalid;
  logic [1:0]         r_bresp;

  rstate_e            r_rstate;
  logic [ID_W-1:0]    r_rid;
  logic [LEN_W-1:0]   r_rlen;
  logic [BW-1:0]      r_rbeat;
  logic [IDX_W-1:0]   r_ridx;
  logic               r_rvalid;
  logic               r_rlast;
  logic [1:0]         r_rresp;

  logic [IDX_W-1:0]   w_aw_idx;
  logic [IDX_W-1:0]   w_ar_idx;
  logic [IDX_W-1:0]   w_ridx_nxt;
  logic [BW-1:0]      w_rbeat_nxt;
  logic               w_wlast_beat;
  logic               w_woob;
  logic               w_ar_oob;
  logic               w_rnxt_oob;
  logic               w_werr_nxt;
  logic               w_ar_hs;
  logic               w_r_adv;
  logic               w_ram_we;
  logic               w_ram_re;
  logic [AW-1:0]      w_ram_raddr;
  logic [DATA_W-1:0]  w_ram_q;

  assign w_aw_idx    = IDX_W'(awaddr[31:OFF]);
  assign w_ar_idx    = IDX_W'(araddr[31:OFF]);
  assign w_ridx_nxt  = r_ridx + IDX_W'(1);
  assign w_rbeat_nxt = r_rbeat + BW'(1);

  assign w_wlast_beat = (r_wbeat == BW'(r_wlen));

`ifdef AXI_MEM_ERR_EN
  assign w_woob     = idx_oob(32'(r_widx), DEPTH);
  assign w_ar_oob   = idx_oob(32'(w_ar_idx), DEPTH);
  assign w_rnxt_oob = idx_oob(32'(w_ridx_nxt), DEPTH);
  assign w_werr_nxt = r_werr | w_woob
                    | (wlast != w_wlast_beat);
`else
  assign w_woob     = 1'b0;
  assign w_ar_oob   = 1'b0;
  assign w_rnxt_oob = 1'b0;
  assign w_werr_nxt = r_werr;
`endif

  assign awready = (r_wstate == W_IDLE) && !reset;
  assign wready  = (r_wstate == W_DATA) && !reset;
  assign bvalid  = r_bvalid && !reset;
  assign bid     = r_awid;
  assign bresp   = r_bresp;

  assign arready = (r_rstate == R_IDLE) && !reset;
  assign rvalid  = r_rvalid && !reset;
  assign rlast   = r_rlast && !reset;
  assign rid     = r_rid;
  assign rresp   = r_rresp;

`ifdef AXI_MEM_ERR_EN
  assign rdata = (r_rresp == RESP_SLVERR) ? '0 : w_ram_q;
`else
  assign rdata = w_ram_q;
`endif

  assign w_ar_hs  = arvalid && arready;
  assign w_r_adv  = (r_rstate == R_DATA) && r_rvalid
                  && rready && !r_rlast;
  assign w_ram_we = wvalid && wready && !w_woob;
  assign w_ram_re = w_ar_hs || w_r_adv;

  assign w_ram_raddr = (r_rstate == R_IDLE)
                     ? w_ar_idx[AW-1:0]
                     : w_ridx_nxt[AW-1:0];

  axi_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_ram_we),
    .i_waddr (r_widx[AW-1:0]),
    .i_wstrb (wstrb),
    .i_wdata (wdata),
    .i_re    (w_ram_re),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_q)
  );

  // Write channel: accept AW, take len+1 beats, then hold B.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wstate <= W_IDLE;
      r_awid   <= '0;
      r_wlen   <= '0;
      r_wbeat  <= '0;
      r_widx   <= '0;
      r_werr   <= 1'b0;
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else begin
      unique case (r_wstate)
        W_IDLE: begin
          if (awvalid) begin
            r_awid   <= awid;
            r_wlen   <= awlen;
            r_wbeat  <= '0;
            r_widx   <= w_aw_idx;
            r_werr   <= 1'b0;
            r_wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            r_wbeat <= r_wbeat + BW'(1);
            r_widx  <= r_widx + IDX_W'(1);
            r_werr  <= w_werr_nxt;
            if (w_wlast_beat) begin
              r_bvalid <= 1'b1;
              r_bresp  <= w_werr_nxt ? RESP_SLVERR
                                     : RESP_OKAY;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            r_bvalid <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read channel: accept AR, stream len+1 beats under rready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rstate <= R_IDLE;
      r_rid    <= '0;
      r_rlen   <= '0;
      r_rbeat  <= '0;
      r_ridx   <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rresp  <= RESP_OKAY;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          if (arvalid) begin
            r_rid    <= arid;
            r_rlen   <= arlen;
            r_rbeat  <= '0;
            r_ridx   <= w_ar_idx;
            r_rvalid <= 1'b1;
            r_rlast  <= (arlen == '0);
            r_rresp  <= w_ar_oob ? RESP_SLVERR
                                 : RESP_OKAY;
            r_rstate <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_rvalid && rready) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_rresp  <= RESP_OKAY;
              r_rstate <= R_IDLE;
            end else begin
              r_rbeat <= w_rbeat_nxt;
              r_ridx  <= w_ridx_nxt;
              r_rlast <= (w_rbeat_nxt == BW'(r_rlen));
              r_rresp <= w_rnxt_oob ? RESP_SLVERR
                                    : RESP_OKAY;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

`ifdef AXI_MEM_ERR_EN
  logic w_unused;
  assign w_unused = ^{awaddr[OFF-1:0],
                      araddr[OFF-1:0]};
`else
  logic w_unused;
  assign w_unused = ^{awaddr[OFF-1:0],
                      araddr[OFF-1:0],
                      w_ridx_nxt[IDX_W-1:AW],
                      wlast};
`endif

endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomized self-checking bench for axi_slave_mem.
// Expected data comes from a byte-level memory model.
module tb_axi_slave_mem;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] mem_m [DEPTH];

  logic [63:0] wr_data [16];
  logic [7:0]  wr_strb [16];
  logic [3:0]  wr_bid;
  logic [1:0]  wr_bresp;
  bit          wr_lat_ok;
  bit          wr_to;

  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic [3:0]  rd_id   [16];
  bit          rd_last [16];
  int          rd_n;
  bit          rd_lat_ok;
  bit          rd_stable;
  bit          rd_to;

  axi_slave_mem dut (
    .clk     (clk),
    .reset   (reset),
    .awid    (awid),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bid     (bid),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .arid    (arid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: apply wr_data/wr_strb as an INCR burst, return bresp.
  function automatic logic [1:0] model_write(
    input logic [31:0] addr,
    input int len
  );
    bit err = 0;
    int unsigned idx;
    for (int b = 0; b <= len; b++) begin
      idx = (addr >> 3) + b;
`ifdef AXI_MEM_ERR_EN
      if (idx >= DEPTH) begin
        err = 1;
        continue;
      end
`endif
      for (int k = 0; k < 8; k++)
        if (wr_strb[b][k])
          mem_m[idx % DEPTH][k*8 +: 8] = wr_data[b][k*8 +: 8];
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [65:0] model_read(
    input logic [31:0] addr,
    input int b
  );
    int unsigned idx;
    idx = (addr >> 3) + b;
`ifdef AXI_MEM_ERR_EN
    if (idx >= DEPTH) return {2'b10, 64'd0};
`endif
    return {2'b00, mem_m[idx % DEPTH]};
  endfunction

  task automatic do_write(
    input logic [3:0] id,
    input logic [31:0] addr,
    input int len
  );
    bit hs;
    int c;
    wr_to = 0;
    wr_lat_ok = 0;
    awid = id; awaddr = addr;
    awlen = 4'(len); awvalid = 1;
    hs = 0; c = 0;
    while (!hs && c < 100) begin
      hs = awready; tick(); c++;
    end
    awvalid = 0;
    if (!hs) wr_to = 1;
    for (int b = 0; b <= len && !wr_to; b++) begin
      wdata = wr_data[b]; wstrb = wr_strb[b];
      wlast = (b == len); wvalid = 1;
      hs = 0; c = 0;
      while (!hs && c < 100) begin
        hs = wready; tick(); c++;
      end
      if (!hs) wr_to = 1;
    end
    wvalid = 0; wlast = 0;
    wr_lat_ok = bvalid;
    bready = 1; hs = 0; c = 0;
    while (!hs && c < 100 && !wr_to) begin
      hs = bvalid;
      if (hs) begin
        wr_bid = bid; wr_bresp = bresp;
      end
      tick(); c++;
    end
    bready = 0;
    if (!hs) wr_to = 1;
  endtask

  task automatic do_read(
    input logic [3:0] id,
    input logic [31:0] addr,
    input int len,
    input bit tog
  );
    bit hs, have_prev;
    logic [70:0] prev;
    int c;
    rd_n = 0; rd_lat_ok = 0;
    rd_stable = 1; rd_to = 0;
    arid = id; araddr = addr;
    arlen = 4'(len); arvalid = 1; rready = 0;
    hs = 0; c = 0;
    while (!hs && c < 100) begin
      hs = arready; tick(); c++;
    end
    arvalid = 0;
    if (!hs) begin
      rd_to = 1;
      return;
    end
    rd_lat_ok = rvalid;
    have_prev = 0; c = 0;
    while (rd_n <= len && c < 200) begin
      rready = tog ? (c % 2 == 1) : 1'b1;
      if (rvalid) begin
        if (have_prev &&
            prev !== {rid, rdata, rresp, rlast})
          rd_stable = 0;
        if (rready && rd_n < 16) begin
          rd_data[rd_n] = rdata;
          rd_resp[rd_n] = rresp;
          rd_id[rd_n]   = rid;
          rd_last[rd_n] = rlast;
          rd_n++;
          have_prev = 0;
        end else begin
          prev = {rid, rdata, rresp, rlast};
          have_prev = 1;
        end
      end
      tick(); c++;
    end
    rready = 0;
    if (rd_n <= len) rd_to = 1;
  endtask

  task automatic fill(input logic [31:0] addr, input int len);
    logic [1:0] eb;
    for (int b = 0; b <= len; b++) begin
      wr_data[b] = {$urandom, $urandom};
      wr_strb[b] = 8'hFF;
    end
    eb = model_write(addr, len);
    do_write(4'(len), addr, len);
    n_checks++;
    if (wr_to || wr_bresp !== eb)
      $display("FAIL fill_bresp got=%b exp=%b to=%0d",
               wr_bresp, eb, wr_to);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) tick();
    n_checks++;
    if ({awready, wready, bvalid, arready, rvalid, rlast}
        !== 6'b0)
      $display("FAIL reset_ctrl got=%b exp=000000",
               {awready, wready, bvalid,
                arready, rvalid, rlast});
    else n_pass++;
    n_checks++;
    if ({bid, rid, bresp, rresp, rdata} !== 76'd0)
      $display("FAIL reset_data got=%h exp=0",
               {bid, rid, bresp, rresp, rdata});
    else n_pass++;
    reset = 0;
    #1;
    n_checks++;
    if ({awready, arready} !== 2'b11)
      $display("FAIL reset_ready got=%b exp=11",
               {awready, arready});
    else n_pass++;
    tick();
  endtask

  task automatic test_burst_write();
    logic [1:0] eb;
    for (int b = 0; b < 4; b++) begin
      wr_data[b] = {$urandom, $urandom};
      wr_strb[b] = 8'hFF;
    end
    eb = model_write(32'h40, 3);
    do_write(4'd3, 32'h40, 3);
    n_checks++;
    if (wr_to || !wr_lat_ok)
      $display("FAIL bw_latency got=%0d exp=1 to=%0d",
               wr_lat_ok, wr_to);
    else n_pass++;
    n_checks++;
    if (wr_bid !== 4'd3)
      $display("FAIL bw_bid got=%0d exp=3", wr_bid);
    else n_pass++;
    n_checks++;
    if (wr_bresp !== eb)
      $display("FAIL bw_bresp got=%b exp=%b",
               wr_bresp, eb);
    else n_pass++;
  endtask

  task automatic test_stall_read();
    logic [65:0] e;
    do_read(4'd5, 32'h40, 3, 1'b1);
    n_checks++;
    if (rd_to || rd_n != 4 || !rd_lat_ok)
      $display("FAIL sr_count got=%0d exp=4 lat=%0d",
               rd_n, rd_lat_ok);
    else n_pass++;
    n_checks++;
    if (!rd_stable)
      $display("FAIL sr_stable got=0 exp=1");
    else n_pass++;
    for (int i = 0; i < rd_n; i++) begin
      e = model_read(32'h40, i);
      n_checks++;
      if ({rd_id[i], rd_last[i], rd_resp[i], rd_data[i]}
          !== {4'd5, (i == 3), e[65:64], e[63:0]})
        $display("FAIL sr_beat%0d got=%h/%0d/%h exp=%h",
                 i, rd_id[i], rd_last[i], rd_data[i],
                 e[63:0]);
      else n_pass++;
    end
    n_checks++;
    if (rvalid !== 1'b0)
      $display("FAIL sr_rvalid_end got=%b exp=0", rvalid);
    else n_pass++;
  endtask

  task automatic test_strobe();
    logic [63:0] lo;
    wr_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    wr_strb[0] = 8'hFF;
    void'(model_write(32'hA0, 0));
    do_write(4'd1, 32'hA0, 0);
    lo = {$urandom, $urandom};
    wr_data[0] = lo;
    wr_strb[0] = 8'h0F;
    void'(model_write(32'hA0, 0));
    do_write(4'd2, 32'hA0, 0);
    do_read(4'd2, 32'hA0, 0, 1'b0);
    n_checks++;
    if (rd_to || rd_data[0] !==
        {32'hFFFF_FFFF, lo[31:0]})
      $display("FAIL strobe got=%h exp=%h", rd_data[0],
               {32'hFFFF_FFFF, lo[31:0]});
    else n_pass++;
  endtask

  task automatic test_concurrent();
    logic [1:0] eb;
    logic [65:0] e;
    fill(32'h640, 15);
    for (int b = 0; b < 16; b++) begin
      wr_data[b] = {$urandom, $urandom};
      wr_strb[b] = 8'($urandom);
    end
    eb = model_write(32'h960, 15);
    fork
      do_write(4'd7, 32'h960, 15);
      do_read(4'd6, 32'h640, 15, 1'b0);
    join
    n_checks++;
    if (wr_to || wr_bresp !== eb || wr_bid !== 4'd7)
      $display("FAIL cc_write got=%b/%0d exp=%b/7",
               wr_bresp, wr_bid, eb);
    else n_pass++;
    n_checks++;
    if (rd_to || rd_n != 16)
      $display("FAIL cc_read_n got=%0d exp=16", rd_n);
    else n_pass++;
    for (int i = 0; i < rd_n; i++) begin
      e = model_read(32'h640, i);
      n_checks++;
      if (rd_data[i] !== e[63:0] || rd_id[i] !== 4'd6)
        $display("FAIL cc_rbeat%0d got=%h exp=%h",
                 i, rd_data[i], e[63:0]);
      else n_pass++;
    end
    do_read(4'd8, 32'h960, 15, 1'b1);
    for (int i = 0; i < rd_n; i++) begin
      e = model_read(32'h960, i);
      n_checks++;
      if (rd_data[i] !== e[63:0])
        $display("FAIL cc_wbeat%0d got=%h exp=%h",
                 i, rd_data[i], e[63:0]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [1:0] eb;
    logic [65:0] e;
    logic [31:0] top;
    top = (DEPTH - 1) * 8;
    fill(32'h0, 0);
    fill(top, 0);
    wr_data[0] = {$urandom, $urandom};
    wr_data[1] = {$urandom, $urandom};
    wr_strb[0] = 8'hFF;
    wr_strb[1] = 8'hFF;
    eb = model_write(top, 1);
    do_write(4'd4, top, 1);
    n_checks++;
    if (wr_to || wr_bresp !== eb)
      $display("FAIL wrap_bresp got=%b exp=%b",
               wr_bresp, eb);
    else n_pass++;
    do_read(4'd4, 32'h0, 0, 1'b0);
    e = model_read(32'h0, 0);
    n_checks++;
    if (rd_to || rd_data[0] !== e[63:0])
      $display("FAIL wrap_word0 got=%h exp=%h",
               rd_data[0], e[63:0]);
    else n_pass++;
    do_read(4'd4, top, 1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      e = model_read(top, i);
      n_checks++;
      if (rd_to || {rd_resp[i], rd_data[i]} !== e)
        $display("FAIL wrap_rd%0d got=%b/%h exp=%b/%h",
                 i, rd_resp[i], rd_data[i],
                 e[65:64], e[63:0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_read();
    int taken, c;
    bit hs;
    logic [65:0] e;
    arid = 4'd2; araddr = 32'h640;
    arlen = 4'd7; arvalid = 1;
    hs = 0; c = 0;
    while (!hs && c < 100) begin
      hs = arready; tick(); c++;
    end
    arvalid = 0; rready = 1;
    taken = 0; c = 0;
    while (taken < 2 && c < 100) begin
      if (rvalid) taken++;
      tick(); c++;
    end
    n_checks++;
    if (!hs || taken != 2 || rvalid !== 1'b1)
      $display("FAIL rmid_setup got=%0d exp=2", taken);
    else n_pass++;
    reset = 1;
    tick();
    n_checks++;
    if ({rvalid, bvalid} !== 2'b00)
      $display("FAIL rmid_rvalid got=%b exp=00",
               {rvalid, bvalid});
    else n_pass++;
    reset = 0;
    arid = 4'd9; araddr = 32'h650;
    arlen = 4'd0; arvalid = 1;
    #1;
    n_checks++;
    if (arready !== 1'b1)
      $display("FAIL rmid_arready got=%b exp=1", arready);
    else n_pass++;
    tick();
    arvalid = 0;
    e = model_read(32'h650, 0);
    n_checks++;
    if ({rvalid, rid, rlast, rdata} !==
        {1'b1, 4'd9, 1'b1, e[63:0]})
      $display("FAIL rmid_newar got=%b/%0d/%b/%h exp=%h",
               rvalid, rid, rlast, rdata, e[63:0]);
    else n_pass++;
    tick();
    rready = 0;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0] eb;
    logic [65:0] e;
    int len;
    for (int k = 0; k < 4; k++)
      fill(32'hC80 + k * 128, 15);
    for (int it = 0; it < 40; it++) begin
      len = $urandom_range(7, 0);
      a = 32'hC80 + 8 * $urandom_range(56, 0);
      if ($urandom_range(1, 0) == 1) begin
        for (int b = 0; b <= len; b++) begin
          wr_data[b] = {$urandom, $urandom};
          wr_strb[b] = 8'($urandom);
        end
        eb = model_write(a, len);
        do_write(4'($urandom), a, len);
        n_checks++;
        if (wr_to || wr_bresp !== eb)
          $display("FAIL rnd_bresp it=%0d got=%b exp=%b",
                   it, wr_bresp, eb);
        else n_pass++;
      end else begin
        do_read(4'(it), a, len, 1'($urandom));
        n_checks++;
        if (rd_to || rd_n != len + 1 || !rd_stable)
          $display("FAIL rnd_rd it=%0d got=%0d exp=%0d",
                   it, rd_n, len + 1);
        else n_pass++;
        for (int i = 0; i < rd_n; i++) begin
          e = model_read(a, i);
          n_checks++;
          if ({rd_last[i], rd_data[i]} !==
              {(i == len), e[63:0]})
            $display("FAIL rnd_beat it=%0d b=%0d got=%h exp=%h",
                     it, i, rd_data[i], e[63:0]);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    reset = 1;
    awid = 0; awaddr = 0; awlen = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0;
    bready = 0;
    arid = 0; araddr = 0; arlen = 0; arvalid = 0;
    rready = 0;
    test_reset();
    test_burst_write();
    test_stall_read();
    test_strobe();
    test_concurrent();
    test_wrap();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
